// File: rtl/sprite_compositor_if.sv
// Signal bundle between the sprite address generator, the sprite ROMs, the VGA pins and the compositor.
interface sprite_compositor_if;
    logic        valid;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [16:0] pixel_addr_bug, pixel_addr_farmer, pixel_addr_green, pixel_addr_orange, pixel_addr_yellow;
    logic        show_bug, show_farmer, show_green, show_orange, show_yellow;
    logic [16:0] rom_addr_bug, rom_addr_farmer, rom_addr_green, rom_addr_orange, rom_addr_yellow;
    logic [11:0] rom_data_bug, rom_data_farmer, rom_data_green, rom_data_orange, rom_data_yellow;
    logic        flash_req;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        out_valid;

    modport master (
        output valid, h_cnt, v_cnt, flash_req,
        output pixel_addr_bug, pixel_addr_farmer, pixel_addr_green, pixel_addr_orange, pixel_addr_yellow,
        output show_bug, show_farmer, show_green, show_orange, show_yellow,
        output rom_data_bug, rom_data_farmer, rom_data_green, rom_data_orange, rom_data_yellow,
        input  rom_addr_bug, rom_addr_farmer, rom_addr_green, rom_addr_orange, rom_addr_yellow,
        input  vga_r, vga_g, vga_b, out_valid
    );

    modport slave (
        input  valid, h_cnt, v_cnt, flash_req,
        input  pixel_addr_bug, pixel_addr_farmer, pixel_addr_green, pixel_addr_orange, pixel_addr_yellow,
        input  show_bug, show_farmer, show_green, show_orange, show_yellow,
        input  rom_data_bug, rom_data_farmer, rom_data_green, rom_data_orange, rom_data_yellow,
        output rom_addr_bug, rom_addr_farmer, rom_addr_green, rom_addr_orange, rom_addr_yellow,
        output vga_r, vga_g, vga_b, out_valid
    );
endinterface

// File: rtl/sprite_compositor.sv
// Sprite pixel back-end: drives the sprite ROMs, aligns returned data with the VGA counters,
// composites layers by priority with colour-key transparency and overlays a timed border flash.
module sprite_compositor #(
    parameter int unsigned ROM_LAT      = 1,
    parameter logic [11:0] TRANSP       = 12'h0F0,
    parameter logic [11:0] BG_A         = 12'h8C4,
    parameter logic [11:0] BG_B         = 12'h7B3,
    parameter logic [11:0] FLASH_RGB    = 12'hF00,
    parameter int unsigned FLASH_FRAMES = 8,
    parameter int unsigned BORDER       = 4
) (
    input logic                clk,
    input logic                rst,
    sprite_compositor_if.slave bus
);
    localparam int unsigned CW = 10;
    localparam int unsigned FW = 8;
    localparam logic [CW-1:0] B_LO       = CW'(BORDER);
    localparam logic [CW-1:0] H_HI       = CW'(640 - BORDER);
    localparam logic [CW-1:0] V_HI       = CW'(480 - BORDER);
    localparam logic [CW-1:0] LANE_W     = CW'(80);
    localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_FRAMES);

    typedef struct packed {
        logic          valid;
        logic          flash;
        logic [CW-1:0] h;
        logic [CW-1:0] v;
        logic          show_farmer;
        logic          show_bug;
        logic          show_yellow;
        logic          show_orange;
        logic          show_green;
    } side_t;

    side_t [ROM_LAT:0] side_q;
    side_t             side_d_c;
    side_t             side_o_c;
    logic [FW-1:0]     flash_cnt;
    logic [FW-1:0]     flash_nxt_c;
    logic              border_c;
    logic [11:0]       pix_c;

    // Flash counter next value; the pixel sampled this cycle sees the post-update state
    always_comb begin
        flash_nxt_c = flash_cnt;
        if (bus.flash_req)
            flash_nxt_c = FLASH_LOAD;
        else if (bus.valid && bus.h_cnt == '0 && bus.v_cnt == '0 && flash_cnt != '0)
            flash_nxt_c = flash_cnt - FW'(1);

        side_d_c             = '0;
        side_d_c.valid       = bus.valid;
        side_d_c.flash       = (flash_nxt_c != '0);
        side_d_c.h           = bus.h_cnt;
        side_d_c.v           = bus.v_cnt;
        side_d_c.show_farmer = bus.show_farmer;
        side_d_c.show_bug    = bus.show_bug;
        side_d_c.show_yellow = bus.show_yellow;
        side_d_c.show_orange = bus.show_orange;
        side_d_c.show_green  = bus.show_green;
    end

    // Stage A address register plus side-band delay line covering the ROM latency
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rom_addr_bug    <= '0;
            bus.rom_addr_farmer <= '0;
            bus.rom_addr_green  <= '0;
            bus.rom_addr_orange <= '0;
            bus.rom_addr_yellow <= '0;
            flash_cnt           <= '0;
            side_q              <= '0;
        end else begin
            bus.rom_addr_bug    <= bus.pixel_addr_bug;
            bus.rom_addr_farmer <= bus.pixel_addr_farmer;
            bus.rom_addr_green  <= bus.pixel_addr_green;
            bus.rom_addr_orange <= bus.pixel_addr_orange;
            bus.rom_addr_yellow <= bus.pixel_addr_yellow;
            flash_cnt           <= flash_nxt_c;
            side_q              <= {side_q[ROM_LAT-1:0], side_d_c};
        end
    end

    // Layer selection, lowest priority first so later assignments win
    always_comb begin
        side_o_c = side_q[ROM_LAT];
        border_c = (side_o_c.h < B_LO) || (side_o_c.h >= H_HI) ||
                   (side_o_c.v < B_LO) || (side_o_c.v >= V_HI);
        pix_c    = (((side_o_c.h / LANE_W) & CW'(1)) != '0) ? BG_B : BG_A;
        if (side_o_c.show_green  && bus.rom_data_green  != TRANSP) pix_c = bus.rom_data_green;
        if (side_o_c.show_orange && bus.rom_data_orange != TRANSP) pix_c = bus.rom_data_orange;
        if (side_o_c.show_yellow && bus.rom_data_yellow != TRANSP) pix_c = bus.rom_data_yellow;
        if (side_o_c.show_bug    && bus.rom_data_bug    != TRANSP) pix_c = bus.rom_data_bug;
        if (side_o_c.show_farmer && bus.rom_data_farmer != TRANSP) pix_c = bus.rom_data_farmer;
        if (side_o_c.flash && border_c) pix_c = FLASH_RGB;
        if (!side_o_c.valid) pix_c = '0;
    end

    // Stage O output register
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.vga_r     <= '0;
            bus.vga_g     <= '0;
            bus.vga_b     <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.vga_r     <= pix_c[11:8];
            bus.vga_g     <= pix_c[7:4];
            bus.vga_b     <= pix_c[3:0];
            bus.out_valid <= side_o_c.valid;
        end
    end
endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench: two compositors (ROM_LAT 1 and 3, FLASH_FRAMES 2) driven with identical pixel streams.
module tb_sprite_compositor;
    localparam logic [11:0] TRANSP = 12'h0F0;
    localparam int unsigned LAT0   = 3;
    localparam int unsigned LAT1   = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             vl_d = 1'b0;
    logic [9:0]       h_d = '0;
    logic [9:0]       v_d = '0;
    logic [4:0][16:0] pa_d = '0;   // 0 bug, 1 farmer, 2 green, 3 orange, 4 yellow
    logic [4:0]       sh_d = '0;
    logic             fr_d = 1'b0;

    logic [12:0]      obs_pix [2];
    logic [4:0][16:0] obs_addr [2];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [12:0]      q0 [$];
    logic [12:0]      q1 [$];
    logic [7:0]       fcnt_m = '0;
    logic [4:0][16:0] addr_e = '0;

    always #5 clk = ~clk;

    // ROM art: address 0 holds the colour key, otherwise the data is the low address bits
    function automatic logic [11:0] rom_f(input logic [16:0] a);
        return (a == '0) ? TRANSP : a[11:0];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int unsigned RL = (g == 0) ? 1 : 3;
        sprite_compositor_if bus ();
        logic [4:0][16:0] ra;
        logic [4:0][11:0] rd;
        logic [4:0][16:0] pipe [RL];

        sprite_compositor #(.ROM_LAT(RL), .FLASH_FRAMES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

        assign bus.valid             = vl_d;
        assign bus.h_cnt             = h_d;
        assign bus.v_cnt             = v_d;
        assign bus.flash_req         = fr_d;
        assign bus.pixel_addr_bug    = pa_d[0];
        assign bus.pixel_addr_farmer = pa_d[1];
        assign bus.pixel_addr_green  = pa_d[2];
        assign bus.pixel_addr_orange = pa_d[3];
        assign bus.pixel_addr_yellow = pa_d[4];
        assign bus.show_bug          = sh_d[0];
        assign bus.show_farmer       = sh_d[1];
        assign bus.show_green        = sh_d[2];
        assign bus.show_orange       = sh_d[3];
        assign bus.show_yellow       = sh_d[4];
        assign bus.rom_data_bug      = rd[0];
        assign bus.rom_data_farmer   = rd[1];
        assign bus.rom_data_green    = rd[2];
        assign bus.rom_data_orange   = rd[3];
        assign bus.rom_data_yellow   = rd[4];
        assign ra = {bus.rom_addr_yellow, bus.rom_addr_orange, bus.rom_addr_green,
                     bus.rom_addr_farmer, bus.rom_addr_bug};

        always @(posedge clk) begin
            pipe[0] <= ra;
            for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
        end

        always_comb begin
            for (int k = 0; k < 5; k++) rd[k] = rom_f(pipe[RL-1][k]);
        end

        assign obs_pix[g]  = {bus.out_valid, bus.vga_r, bus.vga_g, bus.vga_b};
        assign obs_addr[g] = ra;
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] pix_model(input logic vl, input logic [9:0] h, input logic [9:0] v,
                                              input logic [4:0][16:0] pa, input logic [4:0] sh,
                                              input logic fl);
        if (!vl) return '0;
        if (fl && (h < 10'd4 || h >= 10'd636 || v < 10'd4 || v >= 10'd476)) return {1'b1, 12'hF00};
        if (sh[1] && rom_f(pa[1]) != TRANSP) return {1'b1, rom_f(pa[1])};
        if (sh[0] && rom_f(pa[0]) != TRANSP) return {1'b1, rom_f(pa[0])};
        if (sh[4] && rom_f(pa[4]) != TRANSP) return {1'b1, rom_f(pa[4])};
        if (sh[3] && rom_f(pa[3]) != TRANSP) return {1'b1, rom_f(pa[3])};
        if (sh[2] && rom_f(pa[2]) != TRANSP) return {1'b1, rom_f(pa[2])};
        return {1'b1, ((h / 10'd80) % 10'd2 == 10'd1) ? 12'h7B3 : 12'h8C4};
    endfunction

    // One pixel clock: drive inputs, push expectation, advance, compare what has come due
    task automatic step(input logic vl, input logic [9:0] h, input logic [9:0] v,
                        input logic [4:0][16:0] pa, input logic [4:0] sh, input logic fr, input logic r);
        logic [12:0] e;
        logic [7:0]  nxt;
        rst = r; vl_d = vl; h_d = h; v_d = v; pa_d = pa; sh_d = sh; fr_d = fr;
        if (r) begin
            fcnt_m = '0;
            e      = '0;
            addr_e = '0;
            foreach (q0[i]) q0[i] = '0;
            foreach (q1[i]) q1[i] = '0;
        end else begin
            if (fr) nxt = 8'd2;
            else if (vl && h == 10'd0 && v == 10'd0 && fcnt_m != 8'd0) nxt = fcnt_m - 8'd1;
            else nxt = fcnt_m;
            fcnt_m = nxt;
            e      = pix_model(vl, h, v, pa, sh, nxt != 8'd0);
            addr_e = pa;
        end
        q0.push_back(e);
        q1.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        check($sformatf("rom_addr lat1 cyc%0d", cyc), 96'(obs_addr[0]), 96'(addr_e));
        check($sformatf("rom_addr lat3 cyc%0d", cyc), 96'(obs_addr[1]), 96'(addr_e));
        if (q0.size() == LAT0) check($sformatf("pixel lat1 cyc%0d", cyc), 96'(obs_pix[0]), 96'(q0.pop_front()));
        if (q1.size() == LAT1) check($sformatf("pixel lat3 cyc%0d", cyc), 96'(obs_pix[1]), 96'(q1.pop_front()));
    endtask

    initial begin
        logic [4:0][16:0] pa;
        logic [4:0]       sh;
        logic [9:0]       h;
        logic [9:0]       v;
        pa = '0;
        sh = '0;
        for (int i = 0; i < 6; i++) step(1'b0, 10'(i), 10'd0, pa, sh, 1'b0, 1'b1);

        // Background lanes with no sprites shown
        step(1'b0, 10'd0, 10'd200, pa, sh, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 10'(i * 20), 10'd200, pa, sh, 1'b0, 1'b0);

        // Farmer over bug, then farmer made transparent two ways
        sh = 5'b00011; pa[1] = 17'h345; pa[0] = 17'hABC;
        step(1'b1, 10'd100, 10'd420, pa, sh, 1'b0, 1'b0);
        pa[1] = 17'h0F0;
        step(1'b1, 10'd100, 10'd420, pa, sh, 1'b0, 1'b0);
        pa[1] = 17'h0;
        step(1'b1, 10'd100, 10'd420, pa, sh, 1'b0, 1'b0);

        // Yellow transparent, then yellow disabled with opaque data
        pa = '0; sh = 5'b10000; pa[4] = 17'h0F0;
        step(1'b1, 10'd100, 10'd300, pa, sh, 1'b0, 1'b0);
        sh = '0; pa[4] = 17'h123;
        step(1'b1, 10'd100, 10'd300, pa, sh, 1'b0, 1'b0);

        // Random layers, coordinates, frame starts, flash requests and the odd reset
        repeat (300) begin
            for (int k = 0; k < 5; k++) begin
                case ($urandom_range(0, 3))
                    0:       pa[k] = '0;
                    1:       pa[k] = 17'h0F0;
                    default: pa[k] = 17'($urandom);
                endcase
            end
            sh = 5'($urandom);
            h  = 10'($urandom_range(0, 639));
            v  = 10'($urandom_range(0, 479));
            if ($urandom_range(0, 9) == 0) begin h = '0; v = '0; end
            step($urandom_range(0, 7) != 0, h, v, pa, sh, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 99) == 0);
        end

        // Reset mid-line, then a run of visible pixels
        pa = '0; sh = 5'b00010; pa[1] = 17'h5A5;
        step(1'b1, 10'd300, 10'd100, pa, sh, 1'b0, 1'b0);
        step(1'b1, 10'd301, 10'd100, pa, sh, 1'b0, 1'b1);
        for (int i = 2; i < 12; i++) step(1'b1, 10'(300 + i), 10'd100, pa, sh, 1'b0, 1'b0);

        // Border flash lasting two frame starts
        sh = '0; pa = '0;
        step(1'b1, 10'd320, 10'd240, pa, sh, 1'b1, 1'b0);
        step(1'b1, 10'd0,   10'd0,   pa, sh, 1'b0, 1'b0);
        step(1'b1, 10'd639, 10'd240, pa, sh, 1'b0, 1'b0);
        step(1'b1, 10'd320, 10'd240, pa, sh, 1'b0, 1'b0);
        step(1'b1, 10'd0,   10'd100, pa, sh, 1'b0, 1'b0);
        step(1'b1, 10'd2,   10'd479, pa, sh, 1'b0, 1'b0);
        step(1'b1, 10'd0,   10'd0,   pa, sh, 1'b0, 1'b0);
        step(1'b1, 10'd639, 10'd240, pa, sh, 1'b0, 1'b0);
        step(1'b1, 10'd0,   10'd100, pa, sh, 1'b0, 1'b0);

        // Restart on a frame-start cycle: load wins over the decrement
        step(1'b1, 10'd320, 10'd240, pa, sh, 1'b1, 1'b0);
        step(1'b1, 10'd0,   10'd0,   pa, sh, 1'b0, 1'b0);
        step(1'b1, 10'd639, 10'd240, pa, sh, 1'b0, 1'b0);
        step(1'b1, 10'd0,   10'd0,   pa, sh, 1'b1, 1'b0);
        step(1'b1, 10'd639, 10'd240, pa, sh, 1'b0, 1'b0);
        step(1'b1, 10'd0,   10'd0,   pa, sh, 1'b0, 1'b0);
        step(1'b1, 10'd639, 10'd240, pa, sh, 1'b0, 1'b0);
        step(1'b1, 10'd0,   10'd0,   pa, sh, 1'b0, 1'b0);
        step(1'b1, 10'd639, 10'd240, pa, sh, 1'b0, 1'b0);

        // Blanking masks an opaque farmer
        sh = 5'b00010; pa[1] = 17'hFFF;
        step(1'b0, 10'd100, 10'd100, pa, sh, 1'b0, 1'b0);
        step(1'b1, 10'd100, 10'd100, pa, sh, 1'b0, 1'b0);
        step(1'b0, 10'd101, 10'd100, pa, sh, 1'b0, 1'b0);

        sh = '0; pa = '0;
        repeat (6) step(1'b0, 10'd0, 10'd0, pa, sh, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
